des_key_schedule: RTL and testbench

//  Iterative DES subkey generator feeding the round datapath of the DES encrypt/decrypt cores.

---
 rtl/des_pkg.sv | 53 +++++
 rtl/des_pc2.sv | 23 ++
 rtl/des_key_schedule.sv | 149 ++++++++++++++
 tb/tb_des_key_schedule.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES constants for the key schedule and the round cores.
//   NROUNDS / KEY_W / SUBKEY_W : fixed DES dimensions
//   CD_W / HALF_W              : width of the C/D register and of each half
//   ksState_t                  : key schedule FSM encoding (IDLE/RUN/DONE)
//   PC1_TABLE                  : 56 source bit numbers (DES 1-based) into the 64-bit key
//   PC2_TABLE                  : 48 source bit numbers (DES 1-based) into the 56-bit C/D
//   SHIFT_TABLE                : per-round left-rotate amounts, round 0..15
// DES numbers bits from 1 at the MSB, so DES bit n of a W-bit vector is [W-n].
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int NROUNDS  = 16;
  localparam int KEY_W    = 64;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ksState_t;

  localparam int PC1_TABLE [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_TABLE [NROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational DES permuted choice 2: selects 48 of the 56 C/D bits.
//   cd_i      in  56  C (cd_i[55:28]) and D (cd_i[27:0]); DES bit 1 = cd_i[55]
//   subkey_o  out 48  round subkey; DES bit 1 = subkey_o[47]
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  // Pure wiring once the loop is unrolled; the eight dropped C/D bits
  // simply have no destination.
  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey_o[6'(SUBKEY_W - 1 - i)] = cd_i[6'(CD_W - PC2_TABLE[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Iterative DES subkey generator. A key is latched through PC-1 into one
// 56-bit C/D register, and the sixteen PC-2 subkeys are then handed out one
// per valid/ready handshake: K1..K16 for encrypt, K16..K1 for decrypt.
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset
//   start         in   1   load key and begin a schedule (honoured in IDLE only)
//   decrypt       in   1   mode captured with start: 0 = K1..K16, 1 = K16..K1
//   key           in   64  DES key, DES bit 1 = key[63]; parity bits ignored
//   busy          out  1   schedule in progress (RUN and DONE)
//   subkey        out  48  PC-2 of the current C/D, DES bit 1 = subkey[47]
//   subkey_valid  out  1   subkey and round_idx are valid
//   subkey_ready  in   1   consumer accepts subkey on valid & ready
//   round_idx     out  4   position of the presented subkey in output order
//   done          out  1   one-cycle pulse after the last subkey is accepted
// -----------------------------------------------------------------------------
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    key,
  output logic                busy,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                done
);

  // PC-1 drops the eight parity bits and reorders the rest into C/D.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++) begin
      r[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TABLE[i])];
    end
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotHalf(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        s,
                                                input logic              right);
    logic [HALF_W-1:0] r;
    r = x;
    case ({right, s})
      3'b001:  r = {x[HALF_W-2:0], x[HALF_W-1]};
      3'b010:  r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      3'b101:  r = {x[0], x[HALF_W-1:1]};
      3'b110:  r = {x[1:0], x[HALF_W-1:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  // C and D rotate independently, so no bit ever moves between halves.
  function automatic logic [CD_W-1:0] rotCd(input logic [CD_W-1:0] cd,
                                            input logic [1:0]      s,
                                            input logic            right);
    return {rotHalf(cd[CD_W-1:HALF_W], s, right), rotHalf(cd[HALF_W-1:0], s, right)};
  endfunction

  ksState_t        state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [3:0]      roundIdx_q, roundIdx_d;
  logic            decMode_q, decMode_d;
  logic [CD_W-1:0] keyPc1;
  logic [3:0]      shiftIdx;

  assign keyPc1 = pc1(key);

  // The shift that moves to the next subkey in output order. For encrypt it
  // is the next round's amount; for decrypt it undoes the rotation that
  // produced the current key. The encrypt index wraps harmlessly on the last
  // handshake, where the C/D contents are no longer consumed.
  always_comb begin
    shiftIdx = roundIdx_q + 4'd1;
    if (decMode_q) begin
      shiftIdx = 4'd15 - roundIdx_q;
    end
  end

  // Next-state and output decode. Decrypt loads PC-1 unrotated because the
  // sixteen shifts total 28, so that value already is the K16 state.
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    roundIdx_d   = roundIdx_q;
    decMode_d    = decMode_q;
    busy         = 1'b0;
    subkey_valid = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cd_d       = decrypt ? keyPc1 : rotCd(keyPc1, SHIFT_TABLE[0], 1'b0);
          roundIdx_d = 4'd0;
          decMode_d  = decrypt;
          state_d    = RUN;
        end
      end
      RUN: begin
        busy         = 1'b1;
        subkey_valid = 1'b1;
        if (subkey_ready) begin
          roundIdx_d = roundIdx_q + 4'd1;
          cd_d       = rotCd(cd_q, SHIFT_TABLE[shiftIdx], decMode_q);
          if (roundIdx_q == 4'd15) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset takes priority over any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cd_q       <= '0;
      roundIdx_q <= 4'd0;
      decMode_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      roundIdx_q <= roundIdx_d;
      decMode_q  <= decMode_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (subkey)
  );

  assign round_idx = roundIdx_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
// Directed bench for des_key_schedule using the classic worked-example key
// 133457799BBCDFF1, whose sixteen subkeys are tabulated below.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        busy;
  logic [47:0] subkey;
  logic        subkeyValid;
  logic        subkeyReady;
  logic [3:0]  roundIdx;
  logic        done;

  int checks;
  int failures;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_ONE = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] PARITY  = 64'h0101010101010101;

  logic [47:0] encKeys [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  // Results collected by runSchedule.
  logic [47:0] got [16];
  int          hsCount;
  int          donePulses;
  int          doneCycle;
  int          stallErrs;
  int          idxErrs;
  int          busyErrs;
  logic        busyAfterDone;
  logic        validPlus2;
  logic [3:0]  idxPlus2;
  logic [47:0] subkeyPlus2;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .busy         (busy),
    .subkey       (subkey),
    .subkey_valid (subkeyValid),
    .subkey_ready (subkeyReady),
    .round_idx    (roundIdx),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyReset();
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Starts a schedule from IDLE and samples every cycle 1 ns after the edge.
  // Cycle n counts edges after the one that accepts start.
  task automatic runSchedule(input logic [63:0] k, input logic dec, input int readyPct,
                             input bit holdStart, input logic [63:0] kAlt);
    logic        prevStall;
    logic [47:0] prevKey;
    logic [3:0]  prevIdx;
    for (int i = 0; i < 16; i++) got[i] = 'x;
    hsCount = 0; donePulses = 0; doneCycle = -1;
    stallErrs = 0; idxErrs = 0; busyErrs = 0;
    busyAfterDone = 1'bx; validPlus2 = 1'bx; idxPlus2 = 'x; subkeyPlus2 = 'x;
    prevStall = 1'b0; prevKey = '0; prevIdx = '0;
    key = k;
    decrypt = dec;
    start = 1'b1;
    subkeyReady = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (holdStart) key = kAlt;
      else start = 1'b0;
      if (done) begin
        donePulses++;
        if (doneCycle < 0) doneCycle = n;
      end
      if ((doneCycle < 0 || n == doneCycle) && busy !== 1'b1) busyErrs++;
      if (prevStall && (subkey !== prevKey || roundIdx !== prevIdx || subkeyValid !== 1'b1))
        stallErrs++;
      if (doneCycle >= 0 && n == doneCycle + 1) busyAfterDone = busy;
      if (doneCycle >= 0 && n == doneCycle + 2) begin
        validPlus2 = subkeyValid;
        idxPlus2 = roundIdx;
        subkeyPlus2 = subkey;
        break;
      end
      subkeyReady = ($urandom_range(99) < readyPct);
      if (doneCycle < 0 && subkeyValid && subkeyReady) begin
        if (hsCount < 16) begin
          got[hsCount] = subkey;
          if (roundIdx !== 4'(hsCount)) idxErrs++;
        end
        hsCount++;
      end
      prevStall = subkeyValid && !subkeyReady;
      prevKey = subkey;
      prevIdx = roundIdx;
    end
    subkeyReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (subkeyValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", subkeyValid); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (roundIdx !== 4'd0) begin failures++; $display("[TB] FAIL reset_idx got=%0d exp=0", roundIdx); end
    checks++; if (subkey !== 48'h0) begin failures++; $display("[TB] FAIL reset_subkey got=%h exp=0", subkey); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    applyReset();
    runSchedule(KEY_A, 1'b0, 100, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== encKeys[i]) begin
        failures++; $display("[TB] FAIL enc_k%0d got=%h exp=%h", i, got[i], encKeys[i]);
      end
    end
    checks++; if (doneCycle != 17) begin failures++; $display("[TB] FAIL enc_done_cycle got=%0d exp=17", doneCycle); end
    checks++; if (hsCount != 16) begin failures++; $display("[TB] FAIL enc_handshakes got=%0d exp=16", hsCount); end
    checks++; if (donePulses != 1) begin failures++; $display("[TB] FAIL enc_done_pulses got=%0d exp=1", donePulses); end
    checks++; if (idxErrs != 0) begin failures++; $display("[TB] FAIL enc_round_idx got=%0d errors exp=0", idxErrs); end
    checks++; if (busyErrs != 0) begin failures++; $display("[TB] FAIL enc_busy got=%0d errors exp=0", busyErrs); end
    checks++; if (busyAfterDone !== 1'b0) begin failures++; $display("[TB] FAIL enc_busy_idle got=%b exp=0", busyAfterDone); end
    checks++; if (validPlus2 !== 1'b0) begin failures++; $display("[TB] FAIL enc_valid_idle got=%b exp=0", validPlus2); end
  endtask

  task automatic test_decrypt();
    applyReset();
    runSchedule(KEY_A, 1'b1, 100, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== encKeys[15 - i]) begin
        failures++; $display("[TB] FAIL dec_k%0d got=%h exp=%h", i, got[i], encKeys[15 - i]);
      end
    end
    checks++; if (doneCycle != 17) begin failures++; $display("[TB] FAIL dec_done_cycle got=%0d exp=17", doneCycle); end
    checks++; if (idxErrs != 0) begin failures++; $display("[TB] FAIL dec_round_idx got=%0d errors exp=0", idxErrs); end
  endtask

  task automatic test_throttle();
    applyReset();
    runSchedule(KEY_A, 1'b0, 50, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== encKeys[i]) begin
        failures++; $display("[TB] FAIL thr_k%0d got=%h exp=%h", i, got[i], encKeys[i]);
      end
    end
    checks++; if (hsCount != 16) begin failures++; $display("[TB] FAIL thr_handshakes got=%0d exp=16", hsCount); end
    checks++; if (donePulses != 1) begin failures++; $display("[TB] FAIL thr_done_pulses got=%0d exp=1", donePulses); end
    checks++; if (stallErrs != 0) begin failures++; $display("[TB] FAIL thr_stall_hold got=%0d errors exp=0", stallErrs); end
    checks++; if (idxErrs != 0) begin failures++; $display("[TB] FAIL thr_round_idx got=%0d errors exp=0", idxErrs); end
    checks++; if (doneCycle < 17) begin failures++; $display("[TB] FAIL thr_done_cycle got=%0d exp>=17", doneCycle); end
  endtask

  task automatic test_parity();
    applyReset();
    runSchedule(KEY_A ^ PARITY, 1'b1, 100, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== encKeys[15 - i]) begin
        failures++; $display("[TB] FAIL par_k%0d got=%h exp=%h", i, got[i], encKeys[15 - i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int lateDone;
    applyReset();
    key = KEY_A;
    decrypt = 1'b0;
    subkeyReady = 1'b1;
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (subkeyValid && roundIdx == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL rst_reach_idx7 got=0 exp=1"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (subkeyValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid got=%b exp=0", subkeyValid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (roundIdx !== 4'd0) begin failures++; $display("[TB] FAIL rst_mid_idx got=%0d exp=0", roundIdx); end
    lateDone = (done === 1'b1) ? 1 : 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lateDone++;
    end
    subkeyReady = 1'b0;
    checks++; if (lateDone != 0) begin failures++; $display("[TB] FAIL rst_mid_done got=%0d pulses exp=0", lateDone); end
    runSchedule(KEY_A, 1'b0, 100, 1'b0, '0);
    checks++; if (got[0] !== encKeys[0]) begin failures++; $display("[TB] FAIL rst_fresh_k1 got=%h exp=%h", got[0], encKeys[0]); end
    checks++; if (got[15] !== encKeys[15]) begin failures++; $display("[TB] FAIL rst_fresh_k16 got=%h exp=%h", got[15], encKeys[15]); end
    checks++; if (doneCycle != 17) begin failures++; $display("[TB] FAIL rst_fresh_done got=%0d exp=17", doneCycle); end
  endtask

  // start stays high and the key switches to all-ones right after acceptance;
  // the second schedule may only begin from IDLE and must use the new key.
  task automatic test_back_to_back();
    applyReset();
    runSchedule(KEY_A, 1'b0, 100, 1'b1, KEY_ONE);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== encKeys[i]) begin
        failures++; $display("[TB] FAIL b2b_k%0d got=%h exp=%h", i, got[i], encKeys[i]);
      end
    end
    checks++; if (doneCycle != 17) begin failures++; $display("[TB] FAIL b2b_done_cycle got=%0d exp=17", doneCycle); end
    checks++; if (donePulses != 1) begin failures++; $display("[TB] FAIL b2b_done_pulses got=%0d exp=1", donePulses); end
    checks++; if (busyAfterDone !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_gap got=%b exp=0", busyAfterDone); end
    checks++; if (validPlus2 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart_valid got=%b exp=1", validPlus2); end
    checks++; if (idxPlus2 !== 4'd0) begin failures++; $display("[TB] FAIL b2b_restart_idx got=%0d exp=0", idxPlus2); end
    checks++; if (subkeyPlus2 !== 48'hFFFFFFFFFFFF) begin failures++; $display("[TB] FAIL b2b_restart_k1 got=%h exp=ffffffffffff", subkeyPlus2); end
    applyReset();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    key = '0;
    subkeyReady = 1'b0;
    $display("[TB] des_key_schedule directed tests");
    test_reset();
    test_encrypt();
    test_decrypt();
    test_throttle();
    test_parity();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
